// File: rtl/pe_grant_decoder_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared types for the priority-encoder grant path.
//   gdec_state_t : grant decoder FSM states (IDLE -> GRANT -> GAP -> IDLE)
//   pe_idx_t     : one encoder result, {none, idx}, at the default index width
//   onehot_dec   : index -> one-hot line, up to 32 lines (index width <= 5)
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int PE_IDX_W  = 2;
    localparam int DEC_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } gdec_state_t;

    typedef struct packed {
        logic                none;
        logic [PE_IDX_W-1:0] idx;
    } pe_idx_t;

    function automatic logic [DEC_MAX_W-1:0] onehot_dec(input logic [4:0] i);
        logic [DEC_MAX_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pe_grant_decoder_if.sv
// ---------------------------------------------------------------------------
// pe_grant_decoder_if
// Bundle between the request priority encoder / grantees and the decoder.
//   idx_valid/idx_ready/idx/idx_none : encoded index handshake (upstream)
//   done                             : grantee finished with its line
//   grant                            : one-hot resource enables
//   busy, drop_cnt                   : status
// master = upstream + grantee side, slave = pe_grant_decoder.
// ---------------------------------------------------------------------------
interface pe_grant_decoder_if #(
    parameter int IDX_W = 2
);
    localparam int N = 2**IDX_W;

    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx;
    logic             idx_none;
    logic             done;
    logic [N-1:0]     grant;
    logic             busy;
    logic [7:0]       drop_cnt;

    modport master (
        output idx_valid, idx, idx_none, done,
        input  idx_ready, grant, busy, drop_cnt
    );

    modport slave (
        input  idx_valid, idx, idx_none, done,
        output idx_ready, grant, busy, drop_cnt
    );

endinterface

// File: rtl/pe_idx_fifo.sv
// ---------------------------------------------------------------------------
// pe_idx_fifo
// Small synchronous FIFO holding encoded indices.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, wdata   : write request (ignored when full)
//   pop, rdata    : read request (ignored when empty); rdata shows the head
//   full, empty   : derived from an occupancy counter, not pointer compare
// A push and a pop on the same edge leave the count unchanged. Data written
// on an edge is never visible at the head until after that edge.
// ---------------------------------------------------------------------------
module pe_idx_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the occupancy counter gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/pe_grant_decoder.sv
// ---------------------------------------------------------------------------
// pe_grant_decoder
// Expands buffered encoder indices into a registered one-hot grant.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; grant drops the moment it asserts
//   bus    : pe_grant_decoder_if.slave
//            idx_valid/idx_ready/idx/idx_none in, done in,
//            grant (one-hot), busy, drop_cnt (saturating) out
// Each grant is held until done or HOLD_CYCLES cycles, followed by a GAP
// cycle and an IDLE cycle, so consecutive grants never overlap.
// IDX_W is limited to 5 (32 grant lines) by onehot_dec.
// ---------------------------------------------------------------------------
module pe_grant_decoder
    import pe_pkg::*;
#(
    parameter int IDX_W       = 2,
    parameter int FIFO_DEPTH  = 2,
    parameter int HOLD_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    pe_grant_decoder_if.slave bus
);
    localparam int N = 2**IDX_W;

    typedef struct packed {
        logic             none;
        logic [IDX_W-1:0] idx;
    } entry_t;

    entry_t      wr_entry, head;
    logic        fifo_full, fifo_empty, push, pop;
    gdec_state_t state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  drop_q, drop_d;

    assign wr_entry = '{none: bus.idx_none, idx: bus.idx};
    assign push     = bus.idx_valid && !fifo_full;

    pe_idx_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        drop_d  = drop_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.none) begin
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    end else begin
                        grant_d = N'(onehot_dec(5'(head.idx)));
                        hold_d  = 8'(HOLD_CYCLES - 1);
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                // hold_q counts the remaining extra cycles; 0 means this is the last.
                if (bus.done || hold_q == 8'd0) begin
                    grant_d = '0;
                    state_d = GAP;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            GAP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            hold_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.idx_ready = !fifo_full;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
    assign bus.drop_cnt  = drop_q;

endmodule
